// File: rtl/nec_prefetch_ctrl_pkg.sv
// NEC-style instruction prefetch controller: shared types.
// Queue depth, address width and FSM state encoding.
package nec_prefetch_ctrl_pkg;

  localparam int IPQ_DEPTH = 8;
  localparam int ADDR_W    = 16;
  localparam int DATA_W    = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_EU_ACCESS,
    ST_DISCARD
  } prefetch_state_e;

  // Bytes a fetch from address a would bring in, given free slots.
  // Returns 0 when nothing may be issued.
  function automatic logic [1:0] fetch_size(
    input logic [ADDR_W-1:0] a,
    input logic [3:0]        free
  );
    logic [1:0] sz;
    sz = 2'd0;
    if (!a[0] && free >= 4'd2) sz = 2'd2;
    if ( a[0] && free >= 4'd1) sz = 2'd1;
    return sz;
  endfunction

endpackage

// File: rtl/nec_prefetch_ctrl_if.sv
// Bus-side request/acknowledge bundle of the prefetch controller.
// master = controller, slave = bus / memory side.
interface nec_prefetch_ctrl_if;
  import nec_prefetch_ctrl_pkg::*;

  logic              bus_req;
  logic              bus_wr;
  logic              bus_word;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic              bus_ack;
  logic [DATA_W-1:0] bus_rdata;

  modport master (
    output bus_req,
    output bus_wr,
    output bus_word,
    output bus_addr,
    output bus_wdata,
    input  bus_ack,
    input  bus_rdata
  );

  modport slave (
    input  bus_req,
    input  bus_wr,
    input  bus_word,
    input  bus_addr,
    input  bus_wdata,
    output bus_ack,
    output bus_rdata
  );

endinterface

// File: rtl/nec_prefetch_ctrl.sv
// Instruction prefetch queue + bus arbiter between prefetch and EU.
// Optional IPQ_STARVE_PRIORITY_EN: fetch beats EU when queue is empty.
module nec_prefetch_ctrl
  import nec_prefetch_ctrl_pkg::*;
#(
  parameter int QUEUE_DEPTH = IPQ_DEPTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   ce_1,
  input  logic                   ce_2,
  input  logic                   set_pc,
  input  logic [ADDR_W-1:0]      new_pc,
  input  logic [ADDR_W-1:0]      dec_pc,
  output logic [7:0][7:0]        ipq,
  output logic [3:0]             ipq_len,
  input  logic                   eu_req,
  input  logic                   eu_wr,
  input  logic [ADDR_W-1:0]      eu_addr,
  input  logic [DATA_W-1:0]      eu_wdata,
  output logic                   eu_ack,
  output logic [DATA_W-1:0]      eu_rdata,
  nec_prefetch_ctrl_if.master    bus
);

  prefetch_state_e   state_q;
  logic [ADDR_W-1:0] fetch_addr_q;
  logic [7:0][7:0]   ipq_q;
  logic              bus_req_q;
  logic              bus_wr_q;
  logic              bus_word_q;
  logic [ADDR_W-1:0] bus_addr_q;
  logic [DATA_W-1:0] bus_wdata_q;
  logic              eu_ack_q;
  logic [DATA_W-1:0] eu_rdata_q;

  logic [ADDR_W-1:0] span_d;
  logic [3:0]        free_d;
  logic [1:0]        fsize_d;
  logic              fetch_ok_d;
  logic              eu_win_d;
  logic [2:0]        widx_d;
  logic [ADDR_W-1:0] fa_next_d;

  // ce_2 has no role in this controller; kept for the phase interface.
  logic unused_ce2;
  assign unused_ce2 = ce_2;

  // Queue occupancy, free space and IDLE arbitration decision.
  always_comb begin
    span_d     = fetch_addr_q - dec_pc;
    ipq_len    = span_d[3:0];
    free_d     = 4'(QUEUE_DEPTH) - ipq_len;
    fsize_d    = fetch_size(fetch_addr_q, free_d);
    fetch_ok_d = (fsize_d != 2'd0) && !set_pc;
`ifdef IPQ_STARVE_PRIORITY_EN
    eu_win_d   = eu_req && !(fetch_ok_d && ipq_len == 4'd0);
`else
    eu_win_d   = eu_req;
`endif
    widx_d     = fetch_addr_q[2:0];
    fa_next_d  = fetch_addr_q + (bus_word_q ? 16'd2 : 16'd1);
  end

  // Prefetch FSM with registered bus/EU outputs and queue writes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      fetch_addr_q <= '0;
      ipq_q        <= '0;
      bus_req_q    <= 1'b0;
      bus_wr_q     <= 1'b0;
      bus_word_q   <= 1'b0;
      bus_addr_q   <= '0;
      bus_wdata_q  <= '0;
      eu_ack_q     <= 1'b0;
      eu_rdata_q   <= '0;
    end else if (ce_1) begin
      eu_ack_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (set_pc) fetch_addr_q <= new_pc;
          if (eu_win_d) begin
            state_q     <= ST_EU_ACCESS;
            bus_req_q   <= 1'b1;
            bus_addr_q  <= eu_addr;
            bus_wr_q    <= eu_wr;
            bus_word_q  <= 1'b1;
            bus_wdata_q <= eu_wdata;
          end else if (fetch_ok_d) begin
            state_q     <= ST_FETCH;
            bus_req_q   <= 1'b1;
            bus_addr_q  <= fetch_addr_q;
            bus_wr_q    <= 1'b0;
            bus_word_q  <= (fsize_d == 2'd2);
            bus_wdata_q <= '0;
          end
        end
        ST_FETCH: begin
          if (set_pc) begin
            fetch_addr_q <= new_pc;
            if (bus.bus_ack) begin
              state_q   <= ST_IDLE;
              bus_req_q <= 1'b0;
            end else begin
              state_q   <= ST_DISCARD;
            end
          end else if (bus.bus_ack) begin
            ipq_q[widx_d] <= bus.bus_rdata[7:0];
            if (bus_word_q)
              ipq_q[widx_d + 3'd1] <= bus.bus_rdata[15:8];
            fetch_addr_q <= fa_next_d;
            state_q      <= ST_IDLE;
            bus_req_q    <= 1'b0;
          end
        end
        ST_EU_ACCESS: begin
          if (set_pc) fetch_addr_q <= new_pc;
          if (bus.bus_ack) begin
            eu_ack_q   <= 1'b1;
            eu_rdata_q <= bus.bus_rdata;
            state_q    <= ST_IDLE;
            bus_req_q  <= 1'b0;
          end
        end
        ST_DISCARD: begin
          if (set_pc) fetch_addr_q <= new_pc;
          if (bus.bus_ack) begin
            state_q   <= ST_IDLE;
            bus_req_q <= 1'b0;
          end
        end
      endcase
    end
  end

  assign ipq           = ipq_q;
  assign eu_ack        = eu_ack_q;
  assign eu_rdata      = eu_rdata_q;
  assign bus.bus_req   = bus_req_q;
  assign bus.bus_wr    = bus_wr_q;
  assign bus.bus_word  = bus_word_q;
  assign bus.bus_addr  = bus_addr_q;
  assign bus.bus_wdata = bus_wdata_q;

endmodule

// File: tb/tb_nec_prefetch_ctrl.sv
// Directed + randomized bench for nec_prefetch_ctrl.
// Reference model tracks the fetch address and a byte-image memory.
module tb_nec_prefetch_ctrl;

`ifdef IPQ_STARVE_PRIORITY_EN
  localparam bit STARVE = 1'b1;
`else
  localparam bit STARVE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        ce_1;
  logic        ce_2;
  logic        set_pc;
  logic [15:0] new_pc;
  logic [15:0] dec_pc;
  logic [7:0][7:0] ipq;
  logic [3:0]  ipq_len;
  logic        eu_req;
  logic        eu_wr;
  logic [15:0] eu_addr;
  logic [15:0] eu_wdata;
  logic        eu_ack;
  logic [15:0] eu_rdata;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  nec_prefetch_ctrl_if bus_if ();

  nec_prefetch_ctrl dut (
    .clk      (clk),
    .reset    (reset),
    .ce_1     (ce_1),
    .ce_2     (ce_2),
    .set_pc   (set_pc),
    .new_pc   (new_pc),
    .dec_pc   (dec_pc),
    .ipq      (ipq),
    .ipq_len  (ipq_len),
    .eu_req   (eu_req),
    .eu_wr    (eu_wr),
    .eu_addr  (eu_addr),
    .eu_wdata (eu_wdata),
    .eu_ack   (eu_ack),
    .eu_rdata (eu_rdata),
    .bus      (bus_if.master)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] mem_b(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h3C;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_req(input string tag);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus_if.bus_req === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    chk({tag, "_req_seen"}, 32'(got), 32'd1);
  endtask

  task automatic start(input logic [15:0] a);
    reset = 1'b1; ce_1 = 1'b1; set_pc = 1'b1;
    new_pc = a; dec_pc = a; eu_req = 1'b0;
    bus_if.bus_ack = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    set_pc = 1'b0;
  endtask

  task automatic serve_fetch(input string tag,
                             input logic [15:0] a,
                             input bit w,
                             input logic [15:0] rd,
                             input int lat);
    wait_req(tag);
    chk({tag, "_addr"}, 32'(bus_if.bus_addr), 32'(a));
    chk({tag, "_word"}, 32'(bus_if.bus_word), 32'(w));
    chk({tag, "_wr"},   32'(bus_if.bus_wr),   32'd0);
    for (int k = 0; k < lat; k++) begin
      tick();
      chk({tag, "_hold"}, 32'(bus_if.bus_req), 32'd1);
    end
    bus_if.bus_rdata = rd;
    bus_if.bus_ack = 1'b1;
    tick();
    bus_if.bus_ack = 1'b0;
    chk({tag, "_done"}, 32'(bus_if.bus_req), 32'd0);
  endtask

  task automatic serve_eu(input string tag,
                          input logic [15:0] a,
                          input bit w,
                          input logic [15:0] wd,
                          input logic [15:0] rd);
    wait_req(tag);
    chk({tag, "_addr"},  32'(bus_if.bus_addr),  32'(a));
    chk({tag, "_word"},  32'(bus_if.bus_word),  32'd1);
    chk({tag, "_wr"},    32'(bus_if.bus_wr),    32'(w));
    chk({tag, "_wdata"}, 32'(bus_if.bus_wdata), 32'(wd));
    bus_if.bus_rdata = rd;
    bus_if.bus_ack = 1'b1;
    tick();
    bus_if.bus_ack = 1'b0;
    eu_req = 1'b0;
    chk({tag, "_ack"},   32'(eu_ack),   32'd1);
    chk({tag, "_rdata"}, 32'(eu_rdata), 32'(rd));
    tick();
    chk({tag, "_ack_pulse"}, 32'(eu_ack), 32'd0);
  endtask

  initial begin
    logic [15:0] m_fa;
    logic [15:0] d;
    logic [15:0] ea;
    logic [15:0] ewd;
    logic [15:0] rd;
    logic [15:0] np;
    logic [15:0] exp_a;
    logic [15:0] ba;
    int          len;
    int          lat;
    bit          eu;
    bit          eu_exp;
    bit          fe;
    bit          wd;
    bit          ewr;
    bit          disc;

    ce_2 = 1'b0; ce_1 = 1'b1; reset = 1'b1;
    set_pc = 1'b0; new_pc = '0; dec_pc = '0;
    eu_req = 1'b0; eu_wr = 1'b0; eu_addr = '0; eu_wdata = '0;
    bus_if.bus_ack = 1'b0; bus_if.bus_rdata = '0;

    // Reset state
    tick(); tick();
    chk("rst_req",   32'(bus_if.bus_req),   32'd0);
    chk("rst_wr",    32'(bus_if.bus_wr),    32'd0);
    chk("rst_word",  32'(bus_if.bus_word),  32'd0);
    chk("rst_addr",  32'(bus_if.bus_addr),  32'd0);
    chk("rst_wdata", 32'(bus_if.bus_wdata), 32'd0);
    chk("rst_euack", 32'(eu_ack),   32'd0);
    chk("rst_eurd",  32'(eu_rdata), 32'd0);
    chk("rst_ipq_lo", ipq[3:0], 32'd0);
    chk("rst_ipq_hi", ipq[7:4], 32'd0);
    chk("rst_len",   32'(ipq_len), 32'd0);
    reset = 1'b0;
    tick();
    chk("rst_first_req",  32'(bus_if.bus_req),  32'd1);
    chk("rst_first_addr", 32'(bus_if.bus_addr), 32'd0);

    // Fill queue with word fetches from 0x0100
    start(16'h0100);
    serve_fetch("f100", 16'h0100, 1'b1, 16'h1234, 0);
    serve_fetch("f102", 16'h0102, 1'b1, 16'h1234, 0);
    serve_fetch("f104", 16'h0104, 1'b1, 16'h1234, 0);
    serve_fetch("f106", 16'h0106, 1'b1, 16'h1234, 0);
    chk("full_len", 32'(ipq_len), 32'd8);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("full_noreq", 32'(bus_if.bus_req), 32'd0);
    end
    chk("full_ipq0", 32'(ipq[0]), 32'h34);
    chk("full_ipq1", 32'(ipq[1]), 32'h12);

    // Odd start: byte fetch then words
    start(16'h0201);
    serve_fetch("o201", 16'h0201, 1'b0, 16'h99AB, 0);
    chk("o201_ipq1", 32'(ipq[1]), 32'hAB);
    serve_fetch("o202", 16'h0202, 1'b1, 16'h5566, 1);
    serve_fetch("o204", 16'h0204, 1'b1, 16'h7788, 0);
    chk("odd_len", 32'(ipq_len), 32'd5);

    // EU request while a fetch is in flight
    start(16'h0300);
    wait_req("np");
    chk("np_addr", 32'(bus_if.bus_addr), 32'h0300);
    eu_req = 1'b1; eu_addr = 16'h0500; eu_wr = 1'b0; eu_wdata = 16'h0;
    tick(); tick();
    chk("np_hold_addr", 32'(bus_if.bus_addr), 32'h0300);
    chk("np_hold_word", 32'(bus_if.bus_word), 32'd1);
    bus_if.bus_rdata = 16'hBEEF; bus_if.bus_ack = 1'b1;
    tick();
    bus_if.bus_ack = 1'b0;
    chk("np_done", 32'(bus_if.bus_req), 32'd0);
    chk("np_ipq0", 32'(ipq[0]), 32'hEF);
    chk("np_ipq1", 32'(ipq[1]), 32'hBE);
    serve_eu("eu500", 16'h0500, 1'b0, 16'h0, 16'hCAFE);

    // set_pc during unacked fetch -> discard
    start(16'h0300);
    wait_req("dis");
    set_pc = 1'b1; new_pc = 16'h0800; dec_pc = 16'h0800;
    tick();
    set_pc = 1'b0;
    chk("dis_req",  32'(bus_if.bus_req),  32'd1);
    chk("dis_addr", 32'(bus_if.bus_addr), 32'h0300);
    chk("dis_len",  32'(ipq_len), 32'd0);
    bus_if.bus_rdata = 16'hAAAA; bus_if.bus_ack = 1'b1;
    tick();
    bus_if.bus_ack = 1'b0;
    chk("dis_done", 32'(bus_if.bus_req), 32'd0);
    chk("dis_ipq0", 32'(ipq[0]), 32'h00);
    serve_fetch("f800", 16'h0800, 1'b1, 16'h2468, 0);
    chk("f800_ipq0", 32'(ipq[0]), 32'h68);

    // set_pc coincident with fetch ack
    start(16'h0300);
    wait_req("coin");
    set_pc = 1'b1; new_pc = 16'h0900; dec_pc = 16'h0900;
    bus_if.bus_rdata = 16'hAAAA; bus_if.bus_ack = 1'b1;
    tick();
    set_pc = 1'b0; bus_if.bus_ack = 1'b0;
    chk("coin_req",  32'(bus_if.bus_req), 32'd0);
    chk("coin_ipq0", 32'(ipq[0]), 32'h00);
    chk("coin_len",  32'(ipq_len), 32'd0);
    serve_fetch("f900", 16'h0900, 1'b1, 16'h1357, 0);
    chk("f900_ipq1", 32'(ipq[1]), 32'h13);

    // Empty queue vs EU request arbitration
    start(16'h0400);
    eu_req = 1'b1; eu_addr = 16'h0600; eu_wr = 1'b0; eu_wdata = 16'h0;
    if (STARVE) begin
      serve_fetch("arb_f", 16'h0400, 1'b1, 16'h1111, 0);
      serve_eu("arb_e", 16'h0600, 1'b0, 16'h0, 16'h7777);
    end else begin
      serve_eu("arb_e", 16'h0600, 1'b0, 16'h0, 16'h7777);
      serve_fetch("arb_f", 16'h0400, 1'b1, 16'h1111, 0);
    end

    // Reset during EU access, late ack ignored
    start(16'h0400);
    serve_fetch("rf", 16'h0400, 1'b1, 16'h1111, 0);
    eu_req = 1'b1; eu_addr = 16'h0700; eu_wr = 1'b1; eu_wdata = 16'h5A5A;
    wait_req("reu");
    chk("reu_addr",  32'(bus_if.bus_addr),  32'h0700);
    chk("reu_wr",    32'(bus_if.bus_wr),    32'd1);
    chk("reu_wdata", 32'(bus_if.bus_wdata), 32'h5A5A);
    reset = 1'b1; eu_req = 1'b0; dec_pc = 16'hFFF8;
    tick();
    chk("reu_rst_req", 32'(bus_if.bus_req), 32'd0);
    reset = 1'b0;
    bus_if.bus_rdata = 16'hDEAD; bus_if.bus_ack = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      chk("reu_euack", 32'(eu_ack), 32'd0);
      chk("reu_req",   32'(bus_if.bus_req), 32'd0);
    end
    bus_if.bus_ack = 1'b0;
    chk("reu_len_wrap", 32'(ipq_len), 32'd8);

    // Address wrap and ce_1 gating
    start(16'hFFFE);
    wait_req("wrap");
    chk("wrap_addr", 32'(bus_if.bus_addr), 32'hFFFE);
    ce_1 = 1'b0;
    bus_if.bus_rdata = 16'h4321; bus_if.bus_ack = 1'b1;
    tick(); tick();
    chk("ce_hold_req", 32'(bus_if.bus_req), 32'd1);
    chk("ce_hold_len", 32'(ipq_len), 32'd0);
    ce_1 = 1'b1;
    tick();
    bus_if.bus_ack = 1'b0;
    chk("wrap_done", 32'(bus_if.bus_req), 32'd0);
    chk("wrap_ipq6", 32'(ipq[6]), 32'h21);
    chk("wrap_ipq7", 32'(ipq[7]), 32'h43);
    serve_fetch("f0000", 16'h0000, 1'b1, 16'h8765, 0);
    chk("wrap_ipq0", 32'(ipq[0]), 32'h65);
    chk("wrap_len",  32'(ipq_len), 32'd4);

    // Randomized traffic against the byte-stream model
    m_fa = 16'($urandom);
    start(m_fa);
    for (int it = 0; it < 80; it++) begin
      d = m_fa - dec_pc;
      len = int'(d);
      dec_pc = dec_pc + 16'($urandom_range(0, len));
      eu = ($urandom_range(0, 3) == 0);
      ea = 16'($urandom); ewr = 1'($urandom); ewd = 16'($urandom);
      eu_req = eu; eu_addr = ea; eu_wr = ewr; eu_wdata = ewd;
      #1;
      d = m_fa - dec_pc;
      len = int'(d);
      chk("rnd_len", 32'(ipq_len), 32'(len));
      eu_exp = eu && !(STARVE && len == 0);
      wd = !m_fa[0];
      fe = !eu_exp && (m_fa[0] ? (len <= 7) : (len <= 6));
      if (!eu_exp && !fe) begin
        tick();
        chk("rnd_noreq", 32'(bus_if.bus_req), 32'd0);
        tick();
        chk("rnd_noreq", 32'(bus_if.bus_req), 32'd0);
        eu_req = 1'b0;
        dec_pc = m_fa - 16'($urandom_range(0, 4));
        continue;
      end
      exp_a = eu_exp ? ea : m_fa;
      tick();
      chk("rnd_req",  32'(bus_if.bus_req),  32'd1);
      chk("rnd_addr", 32'(bus_if.bus_addr), 32'(exp_a));
      chk("rnd_word", 32'(bus_if.bus_word), eu_exp ? 32'd1 : 32'(wd));
      chk("rnd_wr",   32'(bus_if.bus_wr),   eu_exp ? 32'(ewr) : 32'd0);
      if (eu_exp) chk("rnd_wdata", 32'(bus_if.bus_wdata), 32'(ewd));
      lat = $urandom_range(0, 3);
      disc = 1'b0;
      np = 16'h0;
      for (int k = 0; k < lat; k++) begin
        if (k == 0 && !eu_exp && $urandom_range(0, 4) == 0) begin
          np = 16'($urandom);
          set_pc = 1'b1; new_pc = np; dec_pc = np;
          disc = 1'b1;
        end
        tick();
        set_pc = 1'b0;
        chk("rnd_hold", 32'(bus_if.bus_req), 32'd1);
        chk("rnd_hold_addr", 32'(bus_if.bus_addr), 32'(exp_a));
      end
      rd = eu_exp ? 16'($urandom)
                  : {mem_b(m_fa + 16'd1), mem_b(m_fa)};
      bus_if.bus_rdata = rd;
      bus_if.bus_ack = 1'b1;
      tick();
      bus_if.bus_ack = 1'b0;
      eu_req = 1'b0;
      chk("rnd_done", 32'(bus_if.bus_req), 32'd0);
      if (eu_exp) begin
        chk("rnd_euack", 32'(eu_ack),   32'd1);
        chk("rnd_eurd",  32'(eu_rdata), 32'(rd));
      end else if (disc) begin
        m_fa = np;
      end else begin
        m_fa = m_fa + (wd ? 16'd2 : 16'd1);
      end
      d = m_fa - dec_pc;
      len = int'(d);
      for (int i = 0; i < len; i++) begin
        ba = dec_pc + 16'(i);
        chk("rnd_byte", 32'(ipq[ba[2:0]]), 32'(mem_b(ba)));
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/nec_prefetch_ctrl.md
NEC_PREFETCH_CTRL -- requirements
Module: nec_prefetch_ctrl

Interface
REQ-001 Parameter: QUEUE_DEPTH, 8, instruction-queue bytes; fixed at 8 because the ipq index is address[2:0].
REQ-002 Port: clk  in  1  system clock.
REQ-003 Port: reset  in  1  asynchronous, active-high reset.
REQ-004 Port: ce_1, ce_2  in  1 each  phase clock enables; all state updates occur only on clk edges with ce_1=1.
REQ-005 Port: set_pc  in  1  branch; flush the queue and reload the fetch address.
REQ-006 Port: new_pc  in  16  fetch address loaded on set_pc.
REQ-007 Port: dec_pc  in  16  decoder's current pc (next byte to consume).
REQ-008 Port: ipq  out  8x8  queue storage; byte for address A held at ipq[A[2:0]].
REQ-009 Port: ipq_len  out  4  valid bytes from dec_pc, range 0..8.
REQ-010 Port: eu_req, eu_wr  in  1 each  execution-unit access request and write qualifier.
REQ-011 Port: eu_addr, eu_wdata  in  16 each  EU address and write data.
REQ-012 Port: eu_ack  out  1  one-cycle EU completion; eu_rdata  out  16  read data, valid with eu_ack.
REQ-013 Port: bus_req, bus_wr, bus_word  out  1 each  bus request, write, and word (1) / byte (0) transfer.
REQ-014 Port: bus_addr, bus_wdata  out  16 each; bus_ack  in  1; bus_rdata  in  16.

Function
REQ-015 States SHALL be IDLE, FETCH, EU_ACCESS, DISCARD.
REQ-016 ipq_len SHALL equal fetch_addr - dec_pc (16-bit, wrapping), computed combinationally.
REQ-017 In IDLE with eu_req=1, go to EU_ACCESS and drive bus_addr=eu_addr, bus_wr=eu_wr, bus_word=1.
REQ-018 Otherwise, in IDLE with free=8-ipq_len: if fetch_addr even and free>=2, issue a word fetch; if fetch_addr odd and free>=1, issue a byte fetch; then go to FETCH.
REQ-019 bus_req SHALL remain high, and bus_addr, bus_wr, bus_word and bus_wdata SHALL stay stable, in FETCH, EU_ACCESS and DISCARD until bus_ack=1 is sampled.
REQ-020 On FETCH with bus_ack=1, write bus_rdata[7:0] to ipq[fetch_addr[2:0]].
REQ-021 For a word fetch, also write bus_rdata[15:8] to ipq[fetch_addr[2:0]+1], wrapping mod 8.
REQ-022 After a completed FETCH, add 1 or 2 to fetch_addr and return to IDLE.
REQ-023 On EU_ACCESS with bus_ack=1, pulse eu_ack for one ce_1 cycle, present bus_rdata on eu_rdata, and return to IDLE.
REQ-024 An in-flight fetch SHALL never be preempted; eu_req waits for the next IDLE arbitration.
REQ-025 set_pc in IDLE or EU_ACCESS: fetch_addr:=new_pc in the same cycle; an in-progress EU access completes normally.
REQ-026 set_pc in FETCH without bus_ack: fetch_addr:=new_pc, go to DISCARD, drop the returning data, then return to IDLE.
REQ-027 set_pc coincident with a FETCH bus_ack: drop the data, fetch_addr:=new_pc, go to IDLE.
REQ-028 Queue-full (ipq_len=8) SHALL block fetch issue; the 16-bit address wraps from 0xFFFF to 0x0000.

Reset
REQ-029 On reset: state IDLE, fetch_addr 0, ipq all 0x00, bus_req/bus_wr/bus_word/eu_ack 0, bus_addr/bus_wdata/eu_rdata 0.
REQ-030 Reset asserted mid-transaction SHALL abandon the transaction immediately; a later bus_ack is ignored.

Configuration
REQ-031 Macro IPQ_STARVE_PRIORITY_EN defined: in IDLE with ipq_len=0 and eu_req=1, the fetch wins arbitration.
REQ-032 IPQ_STARVE_PRIORITY_EN undefined: eu_req always wins arbitration in IDLE.

Structure
REQ-033 The types package SHALL hold prefetch_state_e and the IPQ_DEPTH=8 constant.
REQ-034 No sub-module; queue storage and FSM are inline.

Verification
REQ-035 Reset, set_pc new_pc=0x0100, bus_ack one cycle after each request, bus_rdata=0x1234: word fetches to 0x0100, 0x0102, 0x0104, 0x0106, then ipq_len=8 with no request while dec_pc=0x0100; ipq[0]=0x34, ipq[1]=0x12.
REQ-036 set_pc new_pc=0x0201: first fetch is a byte fetch at 0x0201, then word fetches at 0x0202 and onward.
REQ-037 eu_req=1 with eu_addr=0x0500 while a fetch is in flight: the fetch completes first, then EU_ACCESS to 0x0500, eu_ack pulses once, and eu_rdata=bus_rdata.
REQ-038 set_pc new_pc=0x0800 during an unacked fetch to 0x0300: DISCARD, no ipq write, next fetch at 0x0800.
REQ-039 ipq_len=0 with eu_req=1 simultaneously: the fetch is issued first with IPQ_STARVE_PRIORITY_EN defined; EU goes first when undefined.
REQ-040 Reset asserted during EU_ACCESS, then bus_ack: eu_ack stays 0 and the FSM remains IDLE.
